// File: rtl/restrict_mode_guard.sv
// -----------------------------------------------------------------------------
// restrict_mode_guard
//
// Operating-mode monitor and request gate. A request condition on any channel
// is only passed through while the block is ARMED and the current operating
// mode is legal (debug_mode high when REQUIRE_DEBUG=1, test_mode low).
// Illegal-mode samples are counted. Each one escalates the FSM to VIOLATION.
// Reaching LOCK_THRESH cumulative violations forces a sticky LOCKED state
// that only reset leaves.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   debug_mode     debug mode indication
//   test_mode      test mode indication
//   restrict_cond  [NUM_CH] per-channel request conditions
//   clr_violation  acknowledge pulse that returns VIOLATION to ARMED
//   restrict_out   [NUM_CH] registered gated requests
//   violation      registered flag, high in VIOLATION or LOCKED
//   viol_count     [CNT_W] saturating cumulative violation count
//   state          [2] current FSM state (SETTLE=0 ARMED=1 VIOLATION=2 LOCKED=3)
// -----------------------------------------------------------------------------
module restrict_mode_guard #(
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = 4,
  parameter int ARM_DELAY     = 2,
  parameter int LOCK_THRESH   = 3,
  parameter bit REQUIRE_DEBUG = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              debug_mode,
  input  logic              test_mode,
  input  logic [NUM_CH-1:0] restrict_cond,
  input  logic              clr_violation,
  output logic [NUM_CH-1:0] restrict_out,
  output logic              violation,
  output logic [CNT_W-1:0]  viol_count,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    SETTLE    = 2'd0,
    ARMED     = 2'd1,
    VIOLATION = 2'd2,
    LOCKED    = 2'd3
  } state_t;

  // ARM_DELAY of 0 and 1 both arm on the first edge after reset release.
  localparam logic [7:0]       ARM_LAST = (ARM_DELAY > 0) ? 8'(ARM_DELAY - 1) : 8'd0;
  localparam logic [CNT_W-1:0] LOCK_LVL = CNT_W'(LOCK_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t              state_q, state_d;
  logic [7:0]          settle_q, settle_d;
  logic [CNT_W-1:0]    count_q, count_d, count_inc;
  logic [NUM_CH-1:0]   restrict_d;
  logic                violation_d;
  logic                bad;

  assign bad       = (REQUIRE_DEBUG && !debug_mode) || test_mode;
  assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    count_d  = count_q;
    unique case (state_q)
      SETTLE: begin
        settle_d = settle_q + 8'd1;
        if (settle_q == ARM_LAST) state_d = ARMED;
      end
      ARMED: begin
        if (bad) begin
          count_d = count_inc;
          state_d = (count_inc >= LOCK_LVL) ? LOCKED : VIOLATION;
        end
      end
      VIOLATION: begin
        // A fresh illegal sample outranks the acknowledge.
        if (bad) begin
          count_d = count_inc;
          if (count_inc >= LOCK_LVL) state_d = LOCKED;
        end else if (clr_violation) begin
          state_d = ARMED;
        end
      end
      LOCKED: begin
        // Absorbing: counter frozen, only reset leaves.
      end
      default: state_d = SETTLE;
    endcase

    restrict_d  = restrict_cond & {NUM_CH{!bad && (state_d == ARMED)}};
    violation_d = (state_d == VIOLATION) || (state_d == LOCKED);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SETTLE;
      settle_q     <= 8'd0;
      count_q      <= '0;
      restrict_out <= '0;
      violation    <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      count_q      <= count_d;
      restrict_out <= restrict_d;
      violation    <= violation_d;
    end
  end

  assign viol_count = count_q;
  assign state      = state_q;

  // Operating-mode restriction and structural invariants.
  restrict property (@(posedge clk) disable iff (!reset_n) !bad);

  locked_sticky: assert property (@(posedge clk) disable iff (!reset_n)
    state_q == LOCKED |=> state_q == LOCKED);

  count_monotonic: assert property (@(posedge clk) disable iff (!reset_n)
    1'b1 |=> count_q >= $past(count_q));

endmodule

// File: tb/tb_restrict_mode_guard.sv
// -----------------------------------------------------------------------------
// tb_restrict_mode_guard
//
// Drives three instances off the same stimulus:
//   dut_a  default parameters
//   dut_b  REQUIRE_DEBUG=0
//   dut_c  CNT_W=2, LOCK_THRESH=3 (lock coincides with counter saturation)
// A behavioural model per instance predicts outputs; predictions are queued
// when a cycle is driven and popped when the DUT outputs are sampled.
// -----------------------------------------------------------------------------
module tb_restrict_mode_guard;

  typedef struct {
    int       st;
    int       cnt;
    int       settle;
    bit [3:0] rout;
    bit       viol;
  } mdl_t;

  typedef struct {
    bit req_dbg;
    int cmax;
    int thr;
    int arm;
  } cfg_t;

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] rout;
    logic       viol;
    logic [3:0] cnt;
  } exp_t;

  localparam cfg_t CFG_A = '{req_dbg: 1'b1, cmax: 15, thr: 3, arm: 2};
  localparam cfg_t CFG_B = '{req_dbg: 1'b0, cmax: 15, thr: 3, arm: 2};
  localparam cfg_t CFG_C = '{req_dbg: 1'b1, cmax: 3,  thr: 3, arm: 2};

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       debug_mode = 1'b1;
  logic       test_mode = 1'b0;
  logic [3:0] restrict_cond = 4'h0;
  logic       clr_violation = 1'b0;

  logic [3:0] a_rout, b_rout, c_rout;
  logic       a_viol, b_viol, c_viol;
  logic [3:0] a_cnt, b_cnt;
  logic [1:0] c_cnt;
  logic [1:0] a_st, b_st, c_st;

  int n_tests = 0;
  int n_fail  = 0;
  int step    = 0;

  mdl_t m_a, m_b, m_c;
  exp_t q_a[$], q_b[$], q_c[$];

  always #5 clk = ~clk;

  restrict_mode_guard dut_a (
    .clk(clk), .reset_n(reset_n), .debug_mode(debug_mode), .test_mode(test_mode),
    .restrict_cond(restrict_cond), .clr_violation(clr_violation),
    .restrict_out(a_rout), .violation(a_viol), .viol_count(a_cnt), .state(a_st)
  );

  restrict_mode_guard #(.REQUIRE_DEBUG(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .debug_mode(debug_mode), .test_mode(test_mode),
    .restrict_cond(restrict_cond), .clr_violation(clr_violation),
    .restrict_out(b_rout), .violation(b_viol), .viol_count(b_cnt), .state(b_st)
  );

  restrict_mode_guard #(.CNT_W(2), .LOCK_THRESH(3)) dut_c (
    .clk(clk), .reset_n(reset_n), .debug_mode(debug_mode), .test_mode(test_mode),
    .restrict_cond(restrict_cond), .clr_violation(clr_violation),
    .restrict_out(c_rout), .violation(c_viol), .viol_count(c_cnt), .state(c_st)
  );

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.st = 0; m.cnt = 0; m.settle = 0; m.rout = 4'h0; m.viol = 1'b0;
    return m;
  endfunction

  // One clock edge of the reference behaviour.
  function automatic mdl_t mdl_step(mdl_t m, cfg_t c, bit dbg, bit tm, bit clr, bit [3:0] cond);
    mdl_t n = m;
    bit   bad = (c.req_dbg && !dbg) || tm;
    case (m.st)
      0: begin
        n.settle = m.settle + 1;
        if (c.arm <= 1 || m.settle == c.arm - 1) n.st = 1;
      end
      1, 2: begin
        if (bad) begin
          n.cnt = (m.cnt + 1 > c.cmax) ? c.cmax : m.cnt + 1;
          n.st  = (n.cnt >= c.thr) ? 3 : 2;
        end else if (m.st == 2 && clr) begin
          n.st = 1;
        end
      end
      default: ;
    endcase
    n.rout = (!bad && n.st == 1) ? cond : 4'h0;
    n.viol = (n.st >= 2);
    return n;
  endfunction

  function automatic exp_t to_exp(mdl_t m);
    exp_t e;
    e.st = 2'(m.st); e.rout = m.rout; e.viol = m.viol; e.cnt = 4'(m.cnt);
    return e;
  endfunction

  task automatic check(string tag, exp_t e, logic [1:0] st, logic [3:0] ro,
                       logic vi, logic [3:0] cn);
    n_tests++;
    assert (st === e.st) else begin
      n_fail++;
      $error("FAIL %s state: got %0d expected %0d", tag, st, e.st);
    end
    n_tests++;
    assert (ro === e.rout) else begin
      n_fail++;
      $error("FAIL %s restrict_out: got %h expected %h", tag, ro, e.rout);
    end
    n_tests++;
    assert (vi === e.viol) else begin
      n_fail++;
      $error("FAIL %s violation: got %b expected %b", tag, vi, e.viol);
    end
    n_tests++;
    assert (cn === e.cnt) else begin
      n_fail++;
      $error("FAIL %s viol_count: got %0d expected %0d", tag, cn, e.cnt);
    end
  endtask

  task automatic push_all();
    q_a.push_back(to_exp(m_a));
    q_b.push_back(to_exp(m_b));
    q_c.push_back(to_exp(m_c));
  endtask

  task automatic compare_all();
    check($sformatf("a@%0d", step), q_a.pop_front(), a_st, a_rout, a_viol, a_cnt);
    check($sformatf("b@%0d", step), q_b.pop_front(), b_st, b_rout, b_viol, b_cnt);
    check($sformatf("c@%0d", step), q_c.pop_front(), c_st, c_rout, c_viol, {2'b00, c_cnt});
    step++;
  endtask

  // Drive one cycle at the falling edge, predict, then sample after the rising edge.
  task automatic cycle(bit rst, bit dbg, bit tm, bit clr, bit [3:0] cond);
    @(negedge clk);
    reset_n       = rst;
    debug_mode    = dbg;
    test_mode     = tm;
    clr_violation = clr;
    restrict_cond = cond;
    if (!rst) begin
      m_a = mdl_reset(); m_b = mdl_reset(); m_c = mdl_reset();
    end else begin
      m_a = mdl_step(m_a, CFG_A, dbg, tm, clr, cond);
      m_b = mdl_step(m_b, CFG_B, dbg, tm, clr, cond);
      m_c = mdl_step(m_c, CFG_C, dbg, tm, clr, cond);
    end
    push_all();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Reset asserted between edges must clear outputs with no clock edge.
  task automatic async_reset();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    m_a = mdl_reset(); m_b = mdl_reset(); m_c = mdl_reset();
    push_all();
    #1;
    compare_all();
  endtask

  initial begin
    m_a = mdl_reset(); m_b = mdl_reset(); m_c = mdl_reset();
    restrict_cond = 4'hF;

    // Reset state
    #2 reset_n = 1'b0;
    push_all();
    #1 compare_all();
    cycle(0, 1, 0, 0, 4'hF);

    // Settle: release, test_mode pulse ignored, then ARMED
    cycle(1, 1, 1, 0, 4'hF);
    cycle(1, 1, 0, 0, 4'hF);
    cycle(1, 1, 0, 0, 4'hF);

    // Single violation, then bad together with clr (bad wins)
    cycle(1, 1, 1, 0, 4'hF);
    cycle(1, 1, 1, 1, 4'hF);
    cycle(1, 1, 0, 0, 4'hF);
    cycle(1, 1, 0, 1, 4'hF);
    cycle(1, 1, 0, 0, 4'hA);

    // debug_mode low: locks a and c; b ignores debug_mode
    cycle(1, 0, 0, 0, 4'hF);
    cycle(1, 0, 0, 1, 4'h5);
    cycle(1, 1, 1, 1, 4'hF);
    cycle(1, 0, 1, 0, 4'hF);
    cycle(1, 1, 0, 1, 4'hF);

    // Reset mid-operation from LOCKED, then full settle again
    async_reset();
    cycle(0, 1, 0, 0, 4'hF);
    cycle(0, 1, 0, 0, 4'hF);
    cycle(1, 1, 0, 0, 4'hF);
    cycle(1, 1, 0, 0, 4'hF);
    cycle(1, 1, 0, 0, 4'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
